wb_stage: RTL and testbench

Writeback stage of the RISC-V pipeline, placed between the MEM stage and the register file. It captures retiring instructions from MEM and selects the writeback value: ALU result, PC+4, or a sign/zero-extended load. For loads it waits on a variable-latency data-memory response and stalls upstream meanwhile. It drives the register file's `wb_en`/`wb_data`/`rd_index` inputs and keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/load_extend.sv | 52 +++++
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load funct3 codes and the writeback FSM state type.
package cpu_pkg;

  // Writeback source select (3 is treated as ALU)
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // IDLE accepts from MEM; WAIT holds a load until its data returns
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } wb_state_e;

endpackage : cpu_pkg

// File: rtl/load_extend.sv
// Combinational load lane selection and sign/zero extension.
// Flags misaligned accesses and unknown funct3 codes; data is 0 then.
module load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the word-aligned read
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend according to funct3; anything unaligned or unknown is flagged
  always_comb begin
    data     = 32'd0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'd0, byte_sel};
      F3_LH: begin
        if (addr[0]) misalign = 1'b1;
        else         data = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (addr[0]) misalign = 1'b1;
        else         data = {16'd0, half_sel};
      end
      F3_LW: begin
        if (addr != 2'd0) misalign = 1'b1;
        else              data = rdata;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule : load_extend

// File: rtl/wb_stage.sv
// Writeback stage: registers the writeback value from MEM (ALU, PC+4 or
// extended load data), stalls upstream while a load waits for its data,
// and counts retired instructions.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [4:0]           mem_rd_index,
  input  logic [1:0]           mem_wb_sel,
  input  logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_alu_result,
  input  logic [31:0]          mem_pc_plus4,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_rvalid,
  output logic                 stall,
  output logic                 wb_en,
  output logic [31:0]          wb_data,
  output logic [4:0]           rd_index,
  output logic                 wb_valid,
  output logic                 load_misalign,
  output logic [INSTRET_W-1:0] instret
);

  wb_state_e state_q, state_d;

  // Pending-load context captured when the load leaves MEM
  logic [4:0] ld_rd_q, ld_rd_d;
  logic       ld_rw_q, ld_rw_d;
  logic [2:0] ld_f3_q, ld_f3_d;
  logic [1:0] ld_addr_q, ld_addr_d;

  // Registered outputs
  logic                 wb_en_q, wb_en_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic [4:0]           rd_index_q, rd_index_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 misalign_q, misalign_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  logic [31:0] ext_data;
  logic        ext_misalign;

  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .funct3   (ld_f3_q),
    .addr     (ld_addr_q),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  // Next-state and next-output logic; strobes default low, data/index hold
  always_comb begin
    state_d    = state_q;
    ld_rd_d    = ld_rd_q;
    ld_rw_d    = ld_rw_q;
    ld_f3_d    = ld_f3_q;
    ld_addr_d  = ld_addr_q;
    wb_en_d    = 1'b0;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    wb_data_d  = wb_data_q;
    rd_index_d = rd_index_q;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          if (mem_wb_sel == WB_LOAD) begin
            ld_rd_d   = mem_rd_index;
            ld_rw_d   = mem_reg_write;
            ld_f3_d   = mem_funct3;
            ld_addr_d = mem_alu_result[1:0];
            state_d   = S_WAIT;
          end else begin
            wb_data_d  = (mem_wb_sel == WB_PC4) ? mem_pc_plus4 : mem_alu_result;
            rd_index_d = mem_rd_index;
            wb_en_d    = mem_reg_write && (mem_rd_index != 5'd0);
            wb_valid_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          wb_valid_d = 1'b1;
          rd_index_d = ld_rd_q;
          if (ext_misalign) begin
            misalign_d = 1'b1;
            wb_data_d  = 32'd0;
          end else begin
            wb_data_d = ext_data;
            wb_en_d   = ld_rw_q && (ld_rd_q != 5'd0);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, wb_valid_d};
  end

  // State and output registers; reset discards any pending load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ld_rd_q    <= 5'd0;
      ld_rw_q    <= 1'b0;
      ld_f3_q    <= 3'd0;
      ld_addr_q  <= 2'd0;
      wb_en_q    <= 1'b0;
      wb_data_q  <= 32'd0;
      rd_index_q <= 5'd0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_rd_q    <= ld_rd_d;
      ld_rw_q    <= ld_rw_d;
      ld_f3_q    <= ld_f3_d;
      ld_addr_q  <= ld_addr_d;
      wb_en_q    <= wb_en_d;
      wb_data_q  <= wb_data_d;
      rd_index_q <= rd_index_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  assign stall         = (state_q == S_WAIT);
  assign wb_en         = wb_en_q;
  assign wb_data       = wb_data_q;
  assign rd_index      = rd_index_q;
  assign wb_valid      = wb_valid_q;
  assign load_misalign = misalign_q;
  assign instret       = instret_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/JAL retirement, load extension
// with multi-cycle responses, misalignment, back-to-back and reset in WAIT.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_index;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        stall;
  logic        wb_en;
  logic [31:0] wb_data;
  logic [4:0]  rd_index;
  logic        wb_valid;
  logic        load_misalign;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_instret = 64'd0;

  wb_stage #(.INSTRET_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_rd_index   (mem_rd_index),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_pc_plus4   (mem_pc_plus4),
    .dmem_rdata     (dmem_rdata),
    .dmem_rvalid    (dmem_rvalid),
    .stall          (stall),
    .wb_en          (wb_en),
    .wb_data        (wb_data),
    .rd_index       (rd_index),
    .wb_valid       (wb_valid),
    .load_misalign  (load_misalign),
    .instret        (instret)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    mem_valid      = 1'b0;
    mem_reg_write  = 1'b0;
    mem_rd_index   = 5'd0;
    mem_wb_sel     = 2'd0;
    mem_funct3     = 3'd0;
    mem_alu_result = 32'd0;
    mem_pc_plus4   = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_mem();
    dmem_rdata  = 32'd0;
    dmem_rvalid = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (stall !== 1'b0 || wb_en !== 1'b0 || wb_valid !== 1'b0 || load_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes stall=%b wb_en=%b wb_valid=%b mis=%b required all 0",
               stall, wb_en, wb_valid, load_misalign);
    end
    checks++;
    if (wb_data !== 32'd0 || rd_index !== 5'd0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_values wb_data=%h rd_index=%0d instret=%0d required 0/0/0",
               wb_data, rd_index, instret);
    end
    $display("reset: stall=%b wb_data=%h instret=%0d", stall, wb_data, instret);
  endtask

  task automatic test_alu();
    mem_valid      = 1'b1;
    mem_reg_write  = 1'b1;
    mem_rd_index   = 5'd5;
    mem_wb_sel     = 2'd0;
    mem_alu_result = 32'h1234_5678;
    mem_pc_plus4   = 32'hAAAA_0004;
    step();
    clear_mem();
    exp_instret++;
    checks++;
    if (wb_en !== 1'b1 || wb_valid !== 1'b1 || rd_index !== 5'd5 || wb_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_retire wb_en=%b wb_valid=%b rd=%0d data=%h required 1/1/5/12345678",
               wb_en, wb_valid, rd_index, wb_data);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL alu_instret got %0d required %0d", instret, exp_instret);
    end
    step();
    checks++;
    if (wb_en !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'h1234_5678 || rd_index !== 5'd5) begin
      errors++;
      $display("FAIL alu_idle_hold wb_en=%b wb_valid=%b data=%h rd=%0d required 0/0/12345678/5",
               wb_en, wb_valid, wb_data, rd_index);
    end
    $display("alu: rd=%0d data=%h instret=%0d", rd_index, wb_data, instret);
  endtask

  task automatic test_jal(input logic [4:0] rd, input logic exp_en);
    mem_valid      = 1'b1;
    mem_reg_write  = 1'b1;
    mem_rd_index   = rd;
    mem_wb_sel     = 2'd2;
    mem_alu_result = 32'hDEAD_0000;
    mem_pc_plus4   = 32'h0000_0104;
    step();
    clear_mem();
    exp_instret++;
    checks++;
    if (wb_data !== 32'h0000_0104 || wb_en !== exp_en || wb_valid !== 1'b1 || rd_index !== rd) begin
      errors++;
      $display("FAIL jal_rd%0d data=%h wb_en=%b wb_valid=%b rd=%0d required 00000104/%b/1/%0d",
               rd, wb_data, wb_en, wb_valid, rd_index, exp_en, rd);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL jal_instret got %0d required %0d", instret, exp_instret);
    end
    step();
    $display("jal: rd=%0d data=%h wb_en=%b", rd, wb_data, exp_en);
  endtask

  // Load with response three cycles after acceptance (stall for 3 cycles)
  task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] exp_data, input logic exp_mis);
    int stall_cnt;
    stall_cnt      = 0;
    mem_valid      = 1'b1;
    mem_reg_write  = 1'b1;
    mem_rd_index   = 5'd7;
    mem_wb_sel     = 2'd1;
    mem_funct3     = f3;
    mem_alu_result = {30'h0400_0000, lo};
    step();
    clear_mem();
    for (int c = 0; c < 3; c++) begin
      if (stall === 1'b1) stall_cnt++;
      checks++;
      if (wb_valid !== 1'b0 || wb_en !== 1'b0) begin
        errors++;
        $display("FAIL %s_wait_quiet cycle %0d wb_valid=%b wb_en=%b required 0/0",
                 name, c, wb_valid, wb_en);
      end
      if (c == 2) begin
        dmem_rdata  = 32'h80FF_FF7F;
        dmem_rvalid = 1'b1;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    exp_instret++;
    checks++;
    if (stall_cnt != 3 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_stall stall_cycles=%0d stall_now=%b required 3/0", name, stall_cnt, stall);
    end
    checks++;
    if (wb_data !== exp_data || load_misalign !== exp_mis || wb_en !== !exp_mis ||
        wb_valid !== 1'b1 || rd_index !== 5'd7) begin
      errors++;
      $display("FAIL %s_result data=%h mis=%b wb_en=%b wb_valid=%b rd=%0d required %h/%b/%b/1/7",
               name, wb_data, load_misalign, wb_en, wb_valid, rd_index, exp_data, exp_mis, !exp_mis);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s_instret got %0d required %0d", name, instret, exp_instret);
    end
    step();
    checks++;
    if (load_misalign !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_single_cycle mis=%b wb_valid=%b required 0/0", name, load_misalign, wb_valid);
    end
    $display("%s: data=%h misalign=%b instret=%0d", name, wb_data, exp_mis, instret);
  endtask

  // LW answered in the first WAIT cycle while the next ALU op is held upstream
  task automatic test_back_to_back();
    int stall_cnt;
    stall_cnt      = 0;
    mem_valid      = 1'b1;
    mem_reg_write  = 1'b1;
    mem_rd_index   = 5'd9;
    mem_wb_sel     = 2'd1;
    mem_funct3     = 3'b010;
    mem_alu_result = 32'h0000_2000;
    step();
    if (stall === 1'b1) stall_cnt++;
    mem_rd_index   = 5'd10;
    mem_wb_sel     = 2'd0;
    mem_funct3     = 3'b000;
    mem_alu_result = 32'hCAFE_F00D;
    dmem_rdata     = 32'h1357_9BDF;
    dmem_rvalid    = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    if (stall === 1'b1) stall_cnt++;
    exp_instret++;
    checks++;
    if (wb_data !== 32'h1357_9BDF || rd_index !== 5'd9 || wb_en !== 1'b1 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load data=%h rd=%0d wb_en=%b wb_valid=%b required 13579bdf/9/1/1",
               wb_data, rd_index, wb_en, wb_valid);
    end
    step();
    clear_mem();
    if (stall === 1'b1) stall_cnt++;
    exp_instret++;
    checks++;
    if (wb_data !== 32'hCAFE_F00D || rd_index !== 5'd10 || wb_en !== 1'b1 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_alu data=%h rd=%0d wb_en=%b wb_valid=%b required cafef00d/10/1/1",
               wb_data, rd_index, wb_en, wb_valid);
    end
    checks++;
    if (stall_cnt != 1 || instret !== exp_instret) begin
      errors++;
      $display("FAIL b2b_stall_instret stall_cycles=%0d instret=%0d required 1/%0d",
               stall_cnt, instret, exp_instret);
    end
    step();
    $display("back_to_back: stall_cycles=%0d instret=%0d", stall_cnt, instret);
  endtask

  // Reset while a load is pending, with the response arriving in the reset cycle
  task automatic test_reset_wait();
    mem_valid      = 1'b1;
    mem_reg_write  = 1'b1;
    mem_rd_index   = 5'd3;
    mem_wb_sel     = 2'd1;
    mem_funct3     = 3'b010;
    mem_alu_result = 32'h0000_0040;
    step();
    clear_mem();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_enter stall=%b required 1", stall);
    end
    rst         = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    dmem_rvalid = 1'b1;
    step();
    rst         = 1'b0;
    dmem_rvalid = 1'b0;
    exp_instret = 64'd0;
    checks++;
    if (wb_en !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL rstwait_discard wb_en=%b wb_valid=%b stall=%b instret=%0d required 0/0/0/0",
               wb_en, wb_valid, stall, instret);
    end
    dmem_rvalid = 1'b1;
    step();
    dmem_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || wb_en !== 1'b0 || stall !== 1'b0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL rstwait_idle_rvalid wb_valid=%b wb_en=%b stall=%b instret=%0d required 0/0/0/0",
               wb_valid, wb_en, stall, instret);
    end
    $display("reset_in_wait: stall=%b instret=%0d", stall, instret);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal(5'd1, 1'b1);
    test_jal(5'd0, 1'b0);
    test_load("lb",  3'b000, 2'd3, 32'hFFFF_FF80, 1'b0);
    test_load("lbu", 3'b100, 2'd3, 32'h0000_0080, 1'b0);
    test_load("lh",  3'b001, 2'd2, 32'hFFFF_80FF, 1'b0);
    test_load("lhu", 3'b101, 2'd0, 32'h0000_FF7F, 1'b0);
    test_load("lw_mis", 3'b010, 2'd2, 32'h0000_0000, 1'b1);
    test_back_to_back();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_wb_stage
